gpio_freq_meter: RTL and testbench

Gated edge counter for a GPIO input pin, measuring the frequency of an asynchronous external signal in Hz. Counts synchronized rising edges of `sig_in` between consecutive one-cycle `gate_tick` pulses, normally the 1 s RCO from the team's 1 s tick counter. At each gate boundary it latches the count and pulses `valid`, for readout through the GPIO wrapper.

---
 rtl/gpio_freq_pkg.sv | 12 +
 rtl/gpio_sync_edge.sv | 59 +++++
 rtl/gpio_freq_meter.sv | 109 ++++++++++
 tb/tb_gpio_freq_meter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_freq_pkg.sv
// Shared types and constants for the GPIO frequency meter.
package gpio_freq_pkg;

    localparam int CNT_W_DEFAULT = 26;
    localparam int FILT_LEN      = 3;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Synchronizes the external pin and emits a one-cycle strobe per rising edge.
// With GPIO_FREQ_GLITCH_FILTER_EN defined, a level filter sits between s2 and sp.
module gpio_sync_edge
    import gpio_freq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic edge_pulse
);

    logic s1;
    logic s2;
    logic sp;
    logic level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
        end
    end

`ifdef GPIO_FREQ_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] hist;
    logic                filt_q;
    logic [FILT_LEN-1:0] win;

    // Level follows s2 only once the last FILT_LEN samples agree; otherwise it holds.
    assign win   = {hist, s2};
    assign level = (&win) ? 1'b1 : ((~|win) ? 1'b0 : filt_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else begin
            hist   <= win[FILT_LEN-2:0];
            filt_q <= level;
        end
    end
`else
    assign level = s2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= 1'b0;
        end else begin
            sp <= level;
        end
    end

    assign edge_pulse = level & ~sp;

endmodule

// File: rtl/gpio_freq_meter.sv
// Gated rising-edge counter: reports edges of sig_in per gate_tick window.
// Optional input glitch filter enabled by defining GPIO_FREQ_GLITCH_FILTER_EN.
module gpio_freq_meter
    import gpio_freq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             gate_tick,
    input  logic             clear,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             overflow
);

    // valid is a one-cycle strobe with no ready: the reader must take freq_out/overflow
    // while valid is high or later, since both hold until the next strobe.

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_d;
    logic             ovf_win;
    logic             ovf_win_d;
    logic [CNT_W-1:0] freq_d;
    logic             ovf_d;
    logic             valid_d;
    logic             edge_pulse;
    logic [CNT_W:0]   sum;
    logic             sat;
    logic [CNT_W-1:0] acc_sat;

    gpio_sync_edge u_sync_edge (
        .clk        (mclk),
        .reset      (reset),
        .sig_in     (sig_in),
        .edge_pulse (edge_pulse)
    );

    // Carry out of the widened add means the accumulator would wrap; clamp instead.
    assign sum     = {1'b0, acc} + (CNT_W + 1)'(edge_pulse);
    assign sat     = sum[CNT_W];
    assign acc_sat = sat ? '1 : sum[CNT_W-1:0];

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        ovf_win_d = ovf_win;
        freq_d    = freq_out;
        ovf_d     = overflow;
        valid_d   = 1'b0;
        if (clear) begin
            state_d   = ARM;
            acc_d     = '0;
            ovf_win_d = 1'b0;
            freq_d    = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state)
                ARM: begin
                    acc_d = '0;
                    if (gate_tick) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (gate_tick) begin
                        // An edge landing on the tick cycle closes with this window.
                        freq_d    = acc_sat;
                        ovf_d     = ovf_win | sat;
                        valid_d   = 1'b1;
                        acc_d     = '0;
                        ovf_win_d = 1'b0;
                    end else begin
                        acc_d = acc_sat;
                        if (sat) begin
                            ovf_win_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ARM;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state    <= ARM;
            acc      <= '0;
            ovf_win  <= 1'b0;
            freq_out <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            ovf_win  <= ovf_win_d;
            freq_out <= freq_d;
            valid    <= valid_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_gpio_freq_meter.sv
// Bench for gpio_freq_meter: directed windows on a 26-bit and a 4-bit instance,
// checked against a window-level edge-count model plus literal expectations.
module tb_gpio_freq_meter;

`ifdef GPIO_FREQ_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 4;
    localparam int GEXP = 5;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 2;
    localparam int GEXP = 10;
`endif
    localparam int MAX26 = (1 << 26) - 1;
    localparam int MAX4  = 15;

    logic        mclk      = 1'b0;
    logic        reset     = 1'b0;
    logic        gate_tick = 1'b0;
    logic        clear     = 1'b0;
    logic        sig_in    = 1'b0;
    logic [25:0] freq26;
    logic        valid26;
    logic        ovf26;
    logic [3:0]  freq4;
    logic        valid4;
    logic        ovf4;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 mclk = ~mclk;

    gpio_freq_meter #(.CNT_W(26)) dut26 (
        .mclk      (mclk),
        .reset     (reset),
        .gate_tick (gate_tick),
        .clear     (clear),
        .sig_in    (sig_in),
        .freq_out  (freq26),
        .valid     (valid26),
        .overflow  (ovf26)
    );

    gpio_freq_meter #(.CNT_W(4)) dut4 (
        .mclk      (mclk),
        .reset     (reset),
        .gate_tick (gate_tick),
        .clear     (clear),
        .sig_in    (sig_in),
        .freq_out  (freq4),
        .valid     (valid4),
        .overflow  (ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Pin samples -> (optionally filtered) level sequence L; a rise of L at
    // sample j is counted at edge j+2. Windows are measured in whole edges.
    logic        p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic [3:0]  lh = 4'b0;
    logic        lcur;
    bit          armed = 1'b0;
    int          cnt = 0;
    int          ev;
    int          tot;
    logic [25:0] exp_f26 = '0;
    logic        exp_o26 = 1'b0;
    logic [3:0]  exp_f4 = '0;
    logic        exp_o4 = 1'b0;
    logic        exp_v = 1'b0;
    logic [25:0] exp_q[$];

    always @(posedge mclk) begin
        if (!reset) begin
            armed = 1'b0; cnt = 0;
            p0 = 1'b0; p1 = 1'b0; p2 = 1'b0; lh = 4'b0;
            exp_f26 = '0; exp_o26 = 1'b0; exp_f4 = '0; exp_o4 = 1'b0; exp_v = 1'b0;
        end else begin
            p2 = p1; p1 = p0; p0 = sig_in;
            if (FILT) lcur = (p0 == p1 && p1 == p2) ? p0 : lh[0];
            else      lcur = p0;
            lh = {lh[2:0], lcur};
            ev = (lh[2] && !lh[3]) ? 1 : 0;
            exp_v = 1'b0;
            if (clear) begin
                armed = 1'b0; cnt = 0;
                exp_f26 = '0; exp_o26 = 1'b0; exp_f4 = '0; exp_o4 = 1'b0;
            end else if (gate_tick) begin
                if (armed) begin
                    tot     = cnt + ev;
                    exp_f26 = (tot > MAX26) ? 26'(MAX26) : 26'(tot);
                    exp_o26 = (tot > MAX26);
                    exp_f4  = (tot > MAX4) ? 4'(MAX4) : 4'(tot);
                    exp_o4  = (tot > MAX4);
                    exp_v   = 1'b1;
                    exp_q.push_back(exp_f26);
                end
                armed = 1'b1;
                cnt   = 0;
            end else if (armed) begin
                cnt = cnt + ev;
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge mclk) begin
        if (!reset) begin
            chk("rst_freq26", freq26, 0);
            chk("rst_valid26", valid26, 0);
            chk("rst_ovf26", ovf26, 0);
            chk("rst_freq4", freq4, 0);
            chk("rst_valid4", valid4, 0);
            chk("rst_ovf4", ovf4, 0);
        end else begin
            chk("freq26", freq26, exp_f26);
            chk("valid26", valid26, exp_v);
            chk("ovf26", ovf26, exp_o26);
            chk("freq4", freq4, exp_f4);
            chk("valid4", valid4, exp_v);
            chk("ovf4", ovf4, exp_o4);
            if (valid26) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_valid: got valid with freq %0d expected no valid at %0t", freq26, $time);
                end else begin
                    chk("sb_freq26", freq26, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit          pend = 1'b0;
    string       pname;
    logic        pv;
    logic [25:0] pf26;
    logic        po26;
    logic [3:0]  pf4;
    logic        po4;

    task automatic expect_next(input string name, input logic v, input logic [25:0] f26,
                               input logic o26, input logic [3:0] f4, input logic o4);
        pend = 1'b1; pname = name; pv = v; pf26 = f26; po26 = o26; pf4 = f4; po4 = o4;
    endtask

    task automatic cyc(input logic g, input logic c, input logic s);
        @(negedge mclk);
        if (pend) begin
            pend = 1'b0;
            chk({pname, "_valid"}, valid26, pv);
            chk({pname, "_freq26"}, freq26, pf26);
            chk({pname, "_ovf26"}, ovf26, po26);
            chk({pname, "_freq4"}, freq4, pf4);
            chk({pname, "_ovf4"}, ovf4, po4);
            chk({pname, "_valid4"}, valid4, pv);
        end
        #1;
        gate_tick = g;
        clear     = c;
        sig_in    = s;
    endtask

    task automatic wave(input int n, input int hi, input int lo, input bit tick_last);
        for (int i = 0; i < n; i++) begin
            cyc(tick_last && (i == n - 1), 1'b0, (i % (hi + lo)) < hi);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge mclk);
        #1;
        reset = 1'b0; gate_tick = 1'b0; clear = 1'b0; sig_in = 1'b0;
        #1;
        chk("midrst_freq26", freq26, 0);
        chk("midrst_valid26", valid26, 0);
        chk("midrst_ovf26", ovf26, 0);
        chk("midrst_freq4", freq4, 0);
        @(negedge mclk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge mclk);
        chk("reset_state_freq26", freq26, 0);
        chk("reset_state_valid26", valid26, 0);
        chk("reset_state_ovf4", ovf4, 0);
        #1 reset = 1'b1;
        idle(3);

        // basic count: 100-cycle windows, 10-cycle input period
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("arm", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        wave(100, 5, 5, 1'b1);
        expect_next("basic1", 1'b1, 26'd10, 1'b0, 4'd10, 1'b0);
        wave(100, 5, 5, 1'b1);
        expect_next("basic2", 1'b1, 26'd10, 1'b0, 4'd10, 1'b0);
        wave(100, 5, 5, 1'b1);
        expect_next("basic3", 1'b1, 26'd10, 1'b0, 4'd10, 1'b0);

        // saturation of the 4-bit instance, then recovery
        wave(160, 4, 4, 1'b1);
        expect_next("sat", 1'b1, 26'd20, 1'b0, 4'd15, 1'b1);
        wave(24, 4, 4, 1'b1);
        expect_next("post_sat", 1'b1, 26'd3, 1'b0, 4'd3, 1'b0);

        // edge counted on the tick cycle belongs to the closing window
        wave(24, 4, 4, 1'b0);
        idle(4);
        for (int i = 0; i <= LAT; i++) cyc(i == LAT, 1'b0, 1'b1);
        expect_next("coinc", 1'b1, 26'd4, 1'b0, 4'd4, 1'b0);
        idle(20);
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("after_coinc", 1'b1, 26'd0, 1'b0, 4'd0, 1'b0);

        // clear mid-window, alone and with a simultaneous tick
        wave(40, 4, 4, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expect_next("clear", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("rearm_clear", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        wave(40, 4, 4, 1'b1);
        expect_next("after_clear", 1'b1, 26'd5, 1'b0, 4'd5, 1'b0);
        wave(24, 4, 4, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        expect_next("clear_tick", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("rearm_clear2", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        wave(24, 4, 4, 1'b1);
        expect_next("after_clear2", 1'b1, 26'd3, 1'b0, 4'd3, 1'b0);

        // reset after 7 edges in a running window
        wave(56, 4, 4, 1'b0);
        pulse_reset();
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("rearm_rst", 1'b0, 26'd0, 1'b0, 4'd0, 1'b0);
        wave(40, 4, 4, 1'b1);
        expect_next("after_rst", 1'b1, 26'd5, 1'b0, 4'd5, 1'b0);

        // 5 short (2-cycle) and 5 long (4-cycle) pulses in one window
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b1);
            idle(4);
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1);
            idle(4);
        end
        cyc(1'b1, 1'b0, 1'b0);
        expect_next("glitch", 1'b1, 26'(GEXP), 1'b0, 4'(GEXP), 1'b0);
        idle(5);

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
